// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter sequencing a single-port word RAM with
// registered read and byte-masked write. One transaction in flight at a time.
// M0 is the CPU load/store/fetch port, M1 is the debug/boot-loader port.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// leave it undefined for fixed priority with M0 winning ties.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1   // 1..15, fits the 4-bit wait counter
) (
  input  logic                  CLK,
  input  logic                  RESET,
  // master 0
  input  logic                  M0_REQ,
  input  logic [ADDR_W-1:0]     M0_ADDR,
  input  logic [DATA_W-1:0]     M0_WDATA,
  input  logic [DATA_W/8-1:0]   M0_WMASK,
  output logic                  m0_busy,
  output logic                  m0_done,
  output logic [DATA_W-1:0]     m0_rdata,
  // master 1
  input  logic                  M1_REQ,
  input  logic [ADDR_W-1:0]     M1_ADDR,
  input  logic [DATA_W-1:0]     M1_WDATA,
  input  logic [DATA_W/8-1:0]   M1_WMASK,
  output logic                  m1_busy,
  output logic                  m1_done,
  output logic [DATA_W-1:0]     m1_rdata,
  // RAM side
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic [DATA_W-1:0]     MEM_RDATA
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_WAIT = 4'(MEM_LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;       // counts WAIT cycles for reads
  logic       owner;     // 0 = M0 owns the RAM, 1 = M1
  logic       grant_m1;  // arbitration result while in IDLE

`ifdef ARB_ROUND_ROBIN_EN
  logic       last;      // master granted most recently

  // Ties go to the master that was not granted last; a lone requester wins.
  always_comb begin
    if (M0_REQ && M1_REQ) grant_m1 = ~last;
    else                  grant_m1 = M1_REQ;
  end
`else
  // Fixed priority: M1 only wins when M0 is not asking.
  always_comb begin
    grant_m1 = M1_REQ && !M0_REQ;
  end
`endif

  // Transaction sequencer: all outputs are registered here so the RAM and the
  // masters see glitch-free strobes; RESET clears everything asynchronously,
  // which also withdraws a pending write enable immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner     <= 1'b0;
      m0_busy   <= 1'b0;
      m0_done   <= 1'b0;
      m0_rdata  <= '0;
      m1_busy   <= 1'b0;
      m1_done   <= 1'b0;
      m1_rdata  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last      <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (M0_REQ || M1_REQ) begin
            // Latch the winner's payload; later payload changes are ignored.
            owner     <= grant_m1;
            mem_addr  <= grant_m1 ? M1_ADDR  : M0_ADDR;
            mem_wdata <= grant_m1 ? M1_WDATA : M0_WDATA;
            mem_wmask <= grant_m1 ? M1_WMASK : M0_WMASK;
            m0_busy   <= !grant_m1;
            m1_busy   <= grant_m1;
`ifdef ARB_ROUND_ROBIN_EN
            last      <= grant_m1;
`endif
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          // Write enables are live for exactly this one cycle.
          mem_wmask <= '0;
          cnt       <= 4'd0;
          if (|mem_wmask) begin
            // Writes complete without waiting and return zero data.
            if (owner) begin
              m1_done  <= 1'b1;
              m1_rdata <= '0;
            end else begin
              m0_done  <= 1'b1;
              m0_rdata <= '0;
            end
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (cnt == LAST_WAIT) begin
            // RAM output is valid in the final wait cycle.
            if (owner) begin
              m1_done  <= 1'b1;
              m1_rdata <= MEM_RDATA;
            end else begin
              m0_done  <= 1'b1;
              m0_rdata <= MEM_RDATA;
            end
            cnt   <= 4'd0;
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        DONE: begin
          m0_done <= 1'b0;
          m1_done <= 1'b0;
          m0_busy <= 1'b0;
          m1_busy <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LATENCY 1 and 3), each with its
// own RAM model and a scoreboard of expected completions (master, data, cycle).
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    int          m;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   dones_a = 0;
  int   dones_b = 0;

  // ---------------- instance A: MEM_LATENCY = 1 ----------------
  logic        a0_req, a1_req;
  logic [31:0] a0_addr, a1_addr, a0_wdata, a1_wdata;
  logic [3:0]  a0_wmask, a1_wmask;
  logic        a0_busy, a0_done, a1_busy, a1_done;
  logic [31:0] a0_rdata, a1_rdata;
  logic [31:0] a_maddr, a_mwdata, a_mrdata;
  logic [3:0]  a_mwmask;
  logic [31:0] ram_a [0:63];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_a (
    .CLK(clk), .RESET(rst),
    .M0_REQ(a0_req), .M0_ADDR(a0_addr), .M0_WDATA(a0_wdata), .M0_WMASK(a0_wmask),
    .m0_busy(a0_busy), .m0_done(a0_done), .m0_rdata(a0_rdata),
    .M1_REQ(a1_req), .M1_ADDR(a1_addr), .M1_WDATA(a1_wdata), .M1_WMASK(a1_wmask),
    .m1_busy(a1_busy), .m1_done(a1_done), .m1_rdata(a1_rdata),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_wmask(a_mwmask),
    .MEM_RDATA(a_mrdata)
  );

  // RAM A: one-cycle registered read, byte-masked write, preloaded in reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram_a[i] <= 32'h5000_0000 + i;
      ram_a[4] <= 32'hDEADBEEF;
      ram_a[8] <= 32'hCAFE0008;
      a_mrdata <= 32'h0;
    end else begin
      a_mrdata <= ram_a[a_maddr[7:2]];
      for (int i = 0; i < 4; i++)
        if (a_mwmask[i]) ram_a[a_maddr[7:2]][i*8 +: 8] <= a_mwdata[i*8 +: 8];
    end
  end

  // ---------------- instance B: MEM_LATENCY = 3 ----------------
  logic        b0_req, b1_req;
  logic [31:0] b0_addr, b1_addr, b0_wdata, b1_wdata;
  logic [3:0]  b0_wmask, b1_wmask;
  logic        b0_busy, b0_done, b1_busy, b1_done;
  logic [31:0] b0_rdata, b1_rdata;
  logic [31:0] b_maddr, b_mwdata, b_mrdata, b_p0, b_p1;
  logic [3:0]  b_mwmask;
  logic [31:0] ram_b [0:63];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut_b (
    .CLK(clk), .RESET(rst),
    .M0_REQ(b0_req), .M0_ADDR(b0_addr), .M0_WDATA(b0_wdata), .M0_WMASK(b0_wmask),
    .m0_busy(b0_busy), .m0_done(b0_done), .m0_rdata(b0_rdata),
    .M1_REQ(b1_req), .M1_ADDR(b1_addr), .M1_WDATA(b1_wdata), .M1_WMASK(b1_wmask),
    .m1_busy(b1_busy), .m1_done(b1_done), .m1_rdata(b1_rdata),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_wmask(b_mwmask),
    .MEM_RDATA(b_mrdata)
  );

  // RAM B: three-stage read pipeline
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram_b[i] <= 32'h7000_0000 + i;
      ram_b[12] <= 32'hA5A55A5A;
      b_p0 <= 32'h0; b_p1 <= 32'h0; b_mrdata <= 32'h0;
    end else begin
      b_p0     <= ram_b[b_maddr[7:2]];
      b_p1     <= b_p0;
      b_mrdata <= b_p1;
      for (int i = 0; i < 4; i++)
        if (b_mwmask[i]) ram_b[b_maddr[7:2]][i*8 +: 8] <= b_mwdata[i*8 +: 8];
    end
  end

  // Scoreboard A: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (a0_done || a1_done) begin
      dones_a++;
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL a_unexpected_done: got m0_done=%0d m1_done=%0d at cyc %0d, required no done",
                 a0_done, a1_done, cyc);
      end else begin
        ea = qa.pop_front();
        if ((a0_done && a1_done) || ((a1_done ? 1 : 0) !== ea.m) ||
            ((a1_done ? a1_rdata : a0_rdata) !== ea.d) || (cyc !== ea.c)) begin
          bad++;
          $display("FAIL a_done: got m%0d data=%h cyc=%0d (both=%0d), required m%0d data=%h cyc=%0d",
                   a1_done ? 1 : 0, a1_done ? a1_rdata : a0_rdata, cyc, a0_done && a1_done,
                   ea.m, ea.d, ea.c);
        end
      end
    end
  end

  // Scoreboard B
  always @(negedge clk) begin
    if (b0_done || b1_done) begin
      dones_b++;
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected_done: got m0_done=%0d m1_done=%0d at cyc %0d, required no done",
                 b0_done, b1_done, cyc);
      end else begin
        eb = qb.pop_front();
        if ((b0_done && b1_done) || ((b1_done ? 1 : 0) !== eb.m) ||
            ((b1_done ? b1_rdata : b0_rdata) !== eb.d) || (cyc !== eb.c)) begin
          bad++;
          $display("FAIL b_done: got m%0d data=%h cyc=%0d (both=%0d), required m%0d data=%h cyc=%0d",
                   b1_done ? 1 : 0, b1_done ? b1_rdata : b0_rdata, cyc, b0_done && b1_done,
                   eb.m, eb.d, eb.c);
        end
      end
    end
  end

  // Wait (bounded) until a scoreboard queue drains; returns ok=0 on timeout
  task automatic wait_drain(input bit use_b, input int budget, output bit ok);
    int k = 0;
    while (((use_b ? qb.size() : qa.size()) != 0) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    ok = ((use_b ? qb.size() : qa.size()) == 0);
    if (!ok) begin
      if (use_b) qb.delete(); else qa.delete();
    end
  endtask

  task automatic idle_inputs();
    a0_req = 0; a1_req = 0; b0_req = 0; b1_req = 0;
    a0_addr = 0; a1_addr = 0; b0_addr = 0; b1_addr = 0;
    a0_wdata = 0; a1_wdata = 0; b0_wdata = 0; b1_wdata = 0;
    a0_wmask = 0; a1_wmask = 0; b0_wmask = 0; b1_wmask = 0;
  endtask

  task automatic test_reset();
    int da, db;
    logic [31:0] st;
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    total++;
    if ({a0_busy, a0_done, a0_rdata, a1_busy, a1_done, a1_rdata, a_maddr, a_mwdata, a_mwmask,
         b0_busy, b0_done, b0_rdata, b1_busy, b1_done, b1_rdata, b_maddr, b_mwdata, b_mwmask} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got a_busy=%b%b a_wmask=%h a_addr=%h b_busy=%b%b, required all zero",
               a0_busy, a1_busy, a_mwmask, a_maddr, b0_busy, b1_busy);
    end
    rst = 0;
    @(negedge clk);
    da = dones_a; db = dones_b;
    // write aborted while its enables are live
    a0_addr = 32'h14; a0_wdata = 32'h11111111; a0_wmask = 4'hF; a0_req = 1;
    @(negedge clk);
    total++;
    if (a_mwmask !== 4'hF) begin
      bad++;
      $display("FAIL reset_issue_wmask: got %h, required f", a_mwmask);
    end
    a0_req = 0;
    rst = 1;
    #1;
    total++;
    if (a_mwmask !== 4'h0 || a0_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_async_wmask: got wmask=%h busy=%b, required wmask=0 busy=0", a_mwmask, a0_busy);
    end
    @(negedge clk);
    rst = 0;
    // read aborted mid-WAIT on the latency-3 instance
    b0_addr = 32'h30; b0_wmask = 4'h0; b0_req = 1;
    repeat (3) @(negedge clk);
    st = {28'h0, b0_busy, b1_busy, b0_done, b1_done};
    total++;
    if (st !== 32'h8) begin
      bad++;
      $display("FAIL reset_wait_state: got busy/done=%h, required 8", st);
    end
    b0_req = 0;
    rst = 1;
    #1;
    total++;
    if ({b0_busy, b0_done, b0_rdata, b_maddr, b_mwmask} !== '0) begin
      bad++;
      $display("FAIL reset_wait_outputs: got busy=%b done=%b addr=%h, required all zero",
               b0_busy, b0_done, b_maddr);
    end
    @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    total++;
    if (dones_a !== da || dones_b !== db) begin
      bad++;
      $display("FAIL reset_no_done: got %0d/%0d extra done pulses, required 0/0", dones_a - da, dones_b - db);
    end
  endtask

  task automatic test_m0_read();
    bit ok;
    @(negedge clk);
    a0_addr = 32'h10; a0_wmask = 4'h0; a0_req = 1;
    qa.push_back('{m: 0, d: 32'hDEADBEEF, c: cyc + 3});
    @(negedge clk);
    total++;
    if (a0_busy !== 1'b1 || a1_busy !== 1'b0 || a_maddr !== 32'h10 || a_mwmask !== 4'h0) begin
      bad++;
      $display("FAIL m0_read_issue: got busy=%b%b addr=%h wmask=%h, required busy=10 addr=10 wmask=0",
               a0_busy, a1_busy, a_maddr, a_mwmask);
    end
    wait_drain(0, 10, ok);
    a0_req = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL m0_read_timeout: got no done, required done"); end
  endtask

  task automatic test_m1_write();
    bit ok;
    @(negedge clk);
    a1_addr = 32'h20; a1_wdata = 32'h12345678; a1_wmask = 4'hF; a1_req = 1;
    qa.push_back('{m: 1, d: 32'h0, c: cyc + 2});
    @(negedge clk);
    total++;
    if (a_mwmask !== 4'hF || a_maddr !== 32'h20 || a_mwdata !== 32'h12345678 || a1_busy !== 1'b1) begin
      bad++;
      $display("FAIL m1_write_issue: got wmask=%h addr=%h wdata=%h busy=%b, required f/20/12345678/1",
               a_mwmask, a_maddr, a_mwdata, a1_busy);
    end
    wait_drain(0, 10, ok);
    a1_req = 0;
    total++;
    if (!ok || a_mwmask !== 4'h0) begin
      bad++;
      $display("FAIL m1_write_done: got ok=%b wmask=%h, required ok=1 wmask=0", ok, a_mwmask);
    end
    // readback through M1
    @(negedge clk);
    a1_wmask = 4'h0; a1_req = 1;
    qa.push_back('{m: 1, d: 32'h12345678, c: cyc + 3});
    wait_drain(0, 10, ok);
    a1_req = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL m1_readback_timeout: got no done, required done"); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] exp_w;
    @(negedge clk);
    a0_addr = 32'h40; a0_wdata = 32'hA0A0A0A0; a0_wmask = 4'hF;
    a1_addr = 32'h44; a1_wdata = 32'hB1B1B1B1; a1_wmask = 4'hF;
    a0_req = 1; a1_req = 1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      qa.push_back('{m: k % 2, d: 32'h0, c: cyc + 2 + 3 * k});
`else
      qa.push_back('{m: 0, d: 32'h0, c: cyc + 2 + 3 * k});
`endif
    end
    wait_drain(0, 30, ok);
    a0_req = 0; a1_req = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL arb_timeout: got pending grants, required 4 done"); end
    repeat (4) @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    exp_w = 32'hB1B1B1B1;
`else
    exp_w = 32'h5000_0011;
`endif
    total++;
    if (ram_a[17] !== exp_w) begin
      bad++;
      $display("FAIL arb_m1_word: got %h, required %h", ram_a[17], exp_w);
    end
  endtask

  task automatic test_payload_change();
    bit ok;
    @(negedge clk);
    a0_addr = 32'h10; a0_wmask = 4'h0; a0_req = 1;
    qa.push_back('{m: 0, d: 32'hDEADBEEF, c: cyc + 3});
    @(negedge clk);
    a0_req = 0; a0_addr = 32'h20; a0_wmask = 4'hF;
    @(negedge clk); #1;
    total++;
    if (a_maddr !== 32'h10 || a_mwmask !== 4'h0) begin
      bad++;
      $display("FAIL payload_latched: got addr=%h wmask=%h, required addr=10 wmask=0", a_maddr, a_mwmask);
    end
    wait_drain(0, 10, ok);
    a0_wmask = 4'h0;
    total++;
    if (!ok) begin bad++; $display("FAIL payload_timeout: got no done, required done"); end
  endtask

  task automatic test_latency3();
    bit ok;
    @(negedge clk);
    b1_addr = 32'h30; b1_wmask = 4'h0; b1_req = 1;
    qb.push_back('{m: 1, d: 32'hA5A55A5A, c: cyc + 5});
    wait_drain(1, 15, ok);
    b1_req = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL lat3_timeout: got no done, required done"); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_m0_read();
    test_m1_write();
    test_back_to_back();
    test_payload_change();
    test_latency3();
    repeat (4) @(negedge clk);
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL final_queues: got %0d/%0d pending, required 0/0", qa.size(), qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
